rotor_inv: RTL and testbench
============================

ROTOR_INV -- requirements
Module: rotor_inv

Interface
REQ-001 Parameter: none; the table size is fixed at 26 letters, ASCII 'A' (8'h41) to 'Z' (8'h5A).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-high (asserted = 1).
REQ-004 set  input  1  one-cycle pulse: load offset, start inverse-table build.
REQ-005 en  input  1  qualifies valid and rot; both are ignored when en=0.
REQ-006 valid  input  1  din carries a character this cycle.
REQ-007 rot  input  1  step rotor position by one this cycle.
REQ-008 din  input  8  input character, ASCII.
REQ-009 offset  input  5  initial rotor position, range 0..25; values above 25 are unsupported.
REQ-010 idx_in  input  208  forward wiring; entry k = idx_in[8k+7:8k] = ASCII image of letter k.
REQ-011 dout  output  8  return-path (inverse-mapped) character.
REQ-012 done  output  1  one-cycle pulse: dout valid.
REQ-013 ready  output  1  inverse table built; characters accepted.
REQ-014 err  output  1  sticky: idx_in is not a permutation (see Configuration).

Function
REQ-015 States: IDLE (no table), BUILD, READY. Reset enters IDLE.
REQ-016 set sampled in any state: pos<=offset, k<=0, err<=0, ready<=0, next state BUILD; set takes priority over valid/rot in the same cycle, and that valid character is dropped.
REQ-017 BUILD: one entry per cycle, inv[idx_in[k]-8'h41]<=k, k=0..25; after the k=25 write the block enters READY and ready=1, so ready is high on the 26th edge after the set edge.
REQ-018 idx_in is required stable from set until ready=1; the block does not register the whole table.
REQ-019 valid && en in IDLE or BUILD: ignored, no done.
REQ-020 READY, valid && en, din in 'A'..'Z': a=(din-8'h41+pos) mod 26; dout=8'h41+((inv[a]-pos) mod 26); all arithmetic is unsigned 5-bit with explicit mod-26 correction, with no out-of-range index.
REQ-021 READY, valid && en, din not a letter: dout=din unchanged.
REQ-022 Latency: 2-cycle pipeline; valid sampled at edge N produces dout/done after edge N+2; done is high for one cycle; one character per cycle throughput; dout holds its value between done pulses.
REQ-023 The character uses pos sampled in its own input cycle.
REQ-024 rot && en in READY: pos<=(pos+1) mod 26, wrapping 25->0; the step applies after that cycle's character.
REQ-025 rot in IDLE/BUILD: ignored.
REQ-026 set during BUILD: the build restarts from k=0, and characters in flight at that time are flushed with no done.

Reset
REQ-027 reset_n=1 sampled at an edge sets state=IDLE, pos=0, k=0, pipeline valid bits=0, dout=8'h00, done=0, ready=0, err=0; reset has priority over all inputs.
REQ-028 Reset mid-BUILD or with characters in flight: table treated invalid, no done issued; inv storage contents need not be cleared.

Configuration
REQ-029 Macro ROTOR_INV_DUPCHK_EN defined: BUILD keeps a 26-bit seen mask; a write to an already-seen slot, or idx_in entry outside 'A'..'Z', sets err=1 (sticky until set/reset); READY is still entered.
REQ-030 ROTOR_INV_DUPCHK_EN undefined: there is no mask logic, err is tied to 0, and out-of-range entries leave the table contents undefined.

Verification
REQ-031 Identity table "ABC..Z", offset 0, set, wait ready, din 'C' -> dout 'C', done exactly 2 cycles after valid.
REQ-032 Forward table "EKMFLGDQVZNTOWYHXUSPAIBRCJ", offset 0: din 'E' -> 'A'; offset 1: din 'A' -> 'V'.
REQ-033 Offset 25, rot pulse with en=1, then din 'E' -> 'A' (pos wrapped to 0); same rot with en=0 -> pos stays 25.
REQ-034 READY, din 8'h20 -> dout 8'h20; valid during BUILD -> no done; set and valid same cycle -> character dropped, ready falls.
REQ-035 ROTOR_INV_DUPCHK_EN defined, table with 'A' at k=0 and k=5 -> err=1 at ready; next set with valid table -> err=0.
REQ-036 reset_n pulsed at BUILD k=10 with a character in flight -> all outputs 0, no done, state IDLE.

Source files
------------

// File: rtl/rotor_inv.sv
// rotor_inv -- return-path (inverse) rotor with a runtime-built inverse table.
//
// A set pulse loads the rotor position from offset and walks idx_in, one entry
// per cycle for 26 cycles, writing inv[letter] = k. The block then accepts
// characters: letters go through the inverse wiring relative to the current
// rotor position, and any other byte passes through unchanged. Characters run
// through a two-stage pipeline, so dout/done follow the sampling edge by two
// edges.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  synchronous reset, active-high (name kept from the existing code)
//   set      one-cycle pulse: load offset and (re)start the table build
//   en       qualifies valid and rot
//   valid    din carries a character this cycle
//   rot      step the rotor position by one after this cycle's character
//   din      input character (ASCII)
//   offset   initial rotor position, 0..25
//   idx_in   forward wiring, entry k = idx_in[8k+7:8k]; held stable during build
//   dout     inverse-mapped character, holds between done pulses
//   done     one-cycle pulse, dout is new
//   ready    inverse table built, characters accepted
//   err      sticky flag: idx_in was not a permutation of 'A'..'Z'
//
// Build option: define ROTOR_INV_DUPCHK_EN to check idx_in during the build
// (duplicate or non-letter entries raise err). Without it err is tied low.

module rotor_inv (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         set,
   input  logic         en,
   input  logic         valid,
   input  logic         rot,
   input  logic [7:0]   din,
   input  logic [4:0]   offset,
   input  logic [207:0] idx_in,
   output logic [7:0]   dout,
   output logic         done,
   output logic         ready,
   output logic         err
);

   localparam int          DATA_W = 8;
   localparam int          NLET   = 26;
   localparam logic [7:0]  CH_A   = 8'h41;
   localparam logic [7:0]  CH_Z   = 8'h5A;

   typedef enum logic [1:0] {IDLE, BUILD, READY} state_t;

   // (x + y) mod 26 for x, y in 0..25
   function automatic logic [4:0] add_mod26(input logic [4:0] x, input logic [4:0] y);
      logic [5:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= 6'd26) s = s - 6'd26;
      return s[4:0];
   endfunction

   // (x - y) mod 26 for x, y in 0..25
   function automatic logic [4:0] sub_mod26(input logic [4:0] x, input logic [4:0] y);
      logic [5:0] s;
      if (x >= y) s = {1'b0, x} - {1'b0, y};
      else        s = {1'b0, x} + 6'd26 - {1'b0, y};
      return s[4:0];
   endfunction

   function automatic logic is_letter(input logic [DATA_W-1:0] c);
      return (c >= CH_A) && (c <= CH_Z);
   endfunction

   // Letter index 0..25; 'A'..'Z' have low five bits 1..26.
   function automatic logic [4:0] letter_idx(input logic [DATA_W-1:0] c);
      return c[4:0] - 5'd1;
   endfunction

   state_t             state_q, state_d;
   logic [4:0]         k_q;
   logic [4:0]         pos_q;
   logic [4:0]         inv [NLET];

   logic [DATA_W-1:0]  ent;
   logic               ent_ok;
   logic [4:0]         ent_idx;
   logic               acc, step, build_wr;

   logic               vld_p0, let_p0;
   logic [DATA_W-1:0]  din_p0;
   logic [4:0]         pos_p0, a_p0;

   logic               vld_p1, let_p1;
   logic [DATA_W-1:0]  din_p1;
   logic [4:0]         pos_p1, inv_p1;

   assign ent      = idx_in[{k_q, 3'b000} +: 8];
   assign ent_ok   = is_letter(ent);
   assign ent_idx  = letter_idx(ent);
   assign build_wr = (state_q == BUILD) && !set && !reset_n;

   assign ready = (state_q == READY);
   // set wins over valid/rot in the same cycle
   assign acc   = en && valid && ready && !set;
   assign step  = en && rot && ready && !set;

   always_comb begin
      state_d = state_q;
      if (set)
         state_d = BUILD;
      else if ((state_q == BUILD) && (k_q == 5'd25))
         state_d = READY;
   end

   // Control: state, build counter, rotor position, pipeline valids, outputs.
   // set flushes every character already in flight.
   always_ff @(posedge clk) begin
      if (reset_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         pos_q   <= '0;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
         done    <= 1'b0;
         dout    <= '0;
      end else begin
         state_q <= state_d;
         vld_p0  <= acc;
         vld_p1  <= vld_p0 && !set;
         done    <= vld_p1 && !set;
         if (set) begin
            pos_q <= offset;
            k_q   <= '0;
         end else begin
            if (step)
               pos_q <= add_mod26(pos_q, 5'd1);
            if (state_q == BUILD)
               k_q <= (k_q == 5'd25) ? 5'd0 : k_q + 5'd1;
         end
         if (vld_p1 && !set)
            dout <= let_p1 ? (CH_A + {3'b000, sub_mod26(inv_p1, pos_p1)}) : din_p1;
      end
   end

   // Inverse table: non-letter entries are skipped so no write lands outside it.
   always_ff @(posedge clk) begin
      if (build_wr && ent_ok)
         inv[ent_idx] <= k_q;
   end

   // ---- stage p0: capture character with the position of its own cycle ----
   always_ff @(posedge clk) begin
      din_p0 <= din;
      let_p0 <= is_letter(din);
      pos_p0 <= pos_q;
   end

   // Non-letters use index 0 so the table read stays in range.
   assign a_p0 = add_mod26(let_p0 ? letter_idx(din_p0) : 5'd0, pos_p0);

   // ---- stage p1: inverse table read ----
   always_ff @(posedge clk) begin
      inv_p1 <= inv[a_p0];
      din_p1 <= din_p0;
      let_p1 <= let_p0;
      pos_p1 <= pos_p0;
   end

`ifdef ROTOR_INV_DUPCHK_EN
   logic [NLET-1:0] seen_q;
   logic            err_q;

   always_ff @(posedge clk) begin
      if (reset_n || set) begin
         seen_q <= '0;
         err_q  <= 1'b0;
      end else if (state_q == BUILD) begin
         if (!ent_ok)
            err_q <= 1'b1;
         else begin
            if (seen_q[ent_idx])
               err_q <= 1'b1;
            seen_q[ent_idx] <= 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rotor_inv.sv
// tb_rotor_inv -- scoreboard bench for rotor_inv.
// Stimulus pushes expected characters (with their sampling cycle) into a queue;
// a monitor on the falling edge pops one entry per done pulse and compares
// dout and latency. Expected characters come from a letter-level model: find
// the wiring entry whose image is the rotated input letter, then un-rotate.

module tb_rotor_inv;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         set = 1'b0;
   logic         en = 1'b0;
   logic         valid = 1'b0;
   logic         rot = 1'b0;
   logic [7:0]   din = 8'h00;
   logic [4:0]   offset = 5'd0;
   logic [207:0] idx_in = '0;
   logic [7:0]   dout;
   logic         done;
   logic         ready;
   logic         err;

   always #5 clk = ~clk;

   rotor_inv dut (
      .clk(clk), .reset_n(reset_n), .set(set), .en(en), .valid(valid), .rot(rot),
      .din(din), .offset(offset), .idx_in(idx_in),
      .dout(dout), .done(done), .ready(ready), .err(err)
   );

`ifdef ROTOR_INV_DUPCHK_EN
   localparam bit DUP_ERR = 1'b1;
`else
   localparam bit DUP_ERR = 1'b0;
`endif

   typedef struct {
      logic [7:0] ch;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_pass = 0;
   int   n_total = 0;
   int   n_done = 0;
   int   cyc = 0;
   int   fwd[26];
   int   pos_m = 0;
   bit   rdy_m = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   // Monitor: one scoreboard entry per done pulse.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         n_done++;
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: got dout %0h, required no done", dout);
         end else begin
            mon_e = exp_q.pop_front();
            chk("dout", {24'h0, dout}, {24'h0, mon_e.ch});
            chk("latency", cyc - mon_e.cyc, 2);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] model_out(input logic [7:0] c);
      int a;
      if (c >= 8'h41 && c <= 8'h5A) begin
         a = (int'(c) - 65 + pos_m) % 26;
         for (int j = 0; j < 26; j++)
            if (fwd[j] == a) return 8'(65 + ((j - pos_m + 26) % 26));
         return 8'hxx;
      end
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One input cycle; the model decides whether a result is due.
   task automatic drive(input bit v, input bit r, input bit e, input logic [7:0] ch);
      exp_t x;
      valid = v; rot = r; en = e; din = ch;
      if (rdy_m && v && e) begin
         x.ch = model_out(ch);
         x.cyc = cyc + 1;
         exp_q.push_back(x);
      end
      if (rdy_m && r && e) pos_m = (pos_m + 1) % 26;
      tick();
      valid = 0; rot = 0; en = 0;
   endtask

   // Directed character with a known answer.
   task automatic send_known(input logic [7:0] ch, input logic [7:0] expch);
      exp_t x;
      valid = 1; en = 1; din = ch;
      x.ch = expch;
      x.cyc = cyc + 1;
      exp_q.push_back(x);
      tick();
      valid = 0; en = 0;
   endtask

   task automatic load_table();
      for (int k = 0; k < 26; k++) idx_in[8*k +: 8] = 8'(65 + fwd[k]);
   endtask

   task automatic start_set(input int off, output int set_cyc);
      offset = 5'(off);
      set = 1;
      set_cyc = cyc + 1;
      pos_m = off;
      rdy_m = 0;
      tick();
      set = 0;
   endtask

   task automatic wait_ready(input int set_cyc, input bit exp_err);
      int n;
      n = 0;
      while (ready !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("ready_latency", cyc - set_cyc, 26);
      chk("err_at_ready", {31'h0, err}, {31'h0, exp_err});
      rdy_m = 1;
   endtask

   task automatic do_set(input int off, input bit exp_err);
      int sc;
      repeat (3) tick();
      load_table();
      start_set(off, sc);
      wait_ready(sc, exp_err);
   endtask

   task automatic shuffle();
      int j, t;
      for (int i = 0; i < 26; i++) fwd[i] = i;
      for (int i = 25; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = fwd[i]; fwd[i] = fwd[j]; fwd[j] = t;
      end
   endtask

   task automatic pulse_reset();
      reset_n = 1;
      tick();
      reset_n = 0;
      rdy_m = 0;
      pos_m = 0;
   endtask

   initial begin
      string enig;
      int    sc, nd;
      logic [7:0] ch;
      enig = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";

      // Reset state
      repeat (2) tick();
      reset_n = 0;
      chk("rst_dout", {24'h0, dout}, 0);
      chk("rst_done", {31'h0, done}, 0);
      chk("rst_ready", {31'h0, ready}, 0);
      chk("rst_err", {31'h0, err}, 0);

      // Identity table
      for (int i = 0; i < 26; i++) fwd[i] = i;
      do_set(0, 0);
      send_known("C", "C");

      // Forward wiring, offsets 0 and 1
      for (int i = 0; i < 26; i++) fwd[i] = int'(enig[i]) - 65;
      do_set(0, 0);
      send_known("E", "A");
      do_set(1, 0);
      send_known("A", "V");

      // Position wrap 25 -> 0, and rot ignored without en
      do_set(25, 0);
      drive(0, 1, 1, 8'h00);
      send_known("E", "A");
      do_set(25, 0);
      drive(0, 1, 0, 8'h00);
      send_known("E", "H");

      // Non-letter passthrough, and dout holds afterwards
      send_known(8'h20, 8'h20);
      repeat (5) tick();
      chk("dout_hold", {24'h0, dout}, 32'h20);

      // valid during BUILD gives no done
      repeat (3) tick();
      nd = n_done;
      start_set(0, sc);
      repeat (5) drive(1, 0, 1, "A");
      repeat (3) tick();
      chk("build_no_done", n_done - nd, 0);
      wait_ready(sc, 0);

      // set and valid in the same cycle: character dropped, ready falls
      repeat (3) tick();
      nd = n_done;
      valid = 1; en = 1; din = "B";
      start_set(0, sc);
      valid = 0; en = 0;
      chk("set_ready_falls", {31'h0, ready}, 0);
      wait_ready(sc, 0);
      chk("set_valid_dropped", n_done - nd, 0);

      // Character in flight when set arrives is flushed
      repeat (3) tick();
      nd = n_done;
      valid = 1; en = 1; din = "Q";
      tick();
      valid = 0; en = 0;
      start_set(0, sc);
      wait_ready(sc, 0);
      chk("set_flush", n_done - nd, 0);

      // Reset with a character in flight
      repeat (3) tick();
      nd = n_done;
      valid = 1; en = 1; din = "K";
      tick();
      valid = 0; en = 0;
      pulse_reset();
      chk("rst_fl_dout", {24'h0, dout}, 0);
      chk("rst_fl_done", {31'h0, done}, 0);
      chk("rst_fl_ready", {31'h0, ready}, 0);
      chk("rst_fl_err", {31'h0, err}, 0);
      repeat (4) tick();
      chk("rst_fl_no_done", n_done - nd, 0);

      // Reset at build step 10: table stays invalid
      start_set(0, sc);
      repeat (10) tick();
      pulse_reset();
      repeat (30) drive(1, 0, 1, "A");
      chk("rst_build_ready", {31'h0, ready}, 0);
      chk("rst_build_no_done", n_done - nd, 0);

      // Duplicate entry ('A' at k=0 and k=5), then a valid table clears err
      for (int i = 0; i < 26; i++) fwd[i] = i;
      fwd[5] = 0;
      do_set(0, DUP_ERR);
      for (int i = 0; i < 26; i++) fwd[i] = i;
      do_set(0, 0);

      // Randomized traffic over random wirings and offsets
      for (int r = 0; r < 4; r++) begin
         shuffle();
         do_set($urandom_range(25, 0), 0);
         for (int n = 0; n < 120; n++) begin
            if ($urandom % 8 != 0) ch = 8'(65 + $urandom_range(25, 0));
            else ch = 8'($urandom % 256);
            drive($urandom % 4 != 0, $urandom % 3 == 0, $urandom % 5 != 0, ch);
         end
      end

      repeat (6) tick();
      chk("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
